// File: rtl/seg7_pkg.sv
// seg7_pkg: shared segment patterns, digit count and digit-index type for the seven-segment scanner
package seg7_pkg;
    localparam int NUM_DIGITS = 6;
    typedef logic [2:0] digit_idx_t;
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_MINUS = 7'h40;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_BLANK = 7'h00;
endpackage

// File: rtl/seg7_scan_if.sv
// seg7_scan_if: value capture inputs and scanned display outputs of the seven-segment driver
interface seg7_scan_if;
    logic        load;
    logic [19:0] bcd;
    logic        sign;
    logic [5:0]  an;
    logic [6:0]  seg;
    logic        frame_done;
    modport master (output load, bcd, sign, input an, seg, frame_done);
    modport slave  (input load, bcd, sign, output an, seg, frame_done);
endinterface

// File: rtl/seg7_decode.sv
// seg7_decode: BCD nibble plus blank flag to active-high {g,f,e,d,c,b,a} pattern
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] i_nib,
    input  logic       i_blank,
    output logic [6:0] o_seg
);
    logic [6:0] w_pat;
    // standard digit glyphs; non-decimal nibbles render as 'E'
    always_comb begin
        case (i_nib)
            4'd0:    w_pat = SEG_0;
            4'd1:    w_pat = SEG_1;
            4'd2:    w_pat = SEG_2;
            4'd3:    w_pat = SEG_3;
            4'd4:    w_pat = SEG_4;
            4'd5:    w_pat = SEG_5;
            4'd6:    w_pat = SEG_6;
            4'd7:    w_pat = SEG_7;
            4'd8:    w_pat = SEG_8;
            4'd9:    w_pat = SEG_9;
            default: w_pat = SEG_E;
        endcase
    end
    assign o_seg = i_blank ? SEG_BLANK : w_pat;
endmodule

// File: rtl/seg7_scan.sv
// seg7_scan: time-multiplexed 6-digit display driver with zero blanking and frame-synchronous updates
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int CLK_DIV        = 50000,
    parameter int BLANK_CYCLES   = 2,
    parameter bit SEG_ACTIVE_LOW = 1,
    parameter bit AN_ACTIVE_LOW  = 1
) (
    input  logic        clk,
    input  logic        rst,
    seg7_scan_if.slave  bus
);
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST_CNT  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] BLANK_CNT = CW'(BLANK_CYCLES);
    localparam digit_idx_t    LAST_IDX  = digit_idx_t'(NUM_DIGITS - 1);
    localparam logic [5:0]    AN_POL    = {6{AN_ACTIVE_LOW}};
    localparam logic [6:0]    SEG_POL   = {7{SEG_ACTIVE_LOW}};

    logic [CW-1:0] r_cnt;
    digit_idx_t    r_idx;
    logic [19:0]   r_sh_bcd, r_dp_bcd;
    logic          r_sh_sign, r_dp_sign;
    logic [5:0]    r_an;
    logic [6:0]    r_seg;
    logic          r_fd;

    logic          w_slot_end, w_frame_end, w_on;
    logic [23:0]   w_ext;
    logic [3:0]    w_nib;
    logic [7:0]    w_lz;
    logic [6:0]    w_dig, w_pat;
    logic [5:0]    w_an;

    assign w_slot_end  = r_cnt == LAST_CNT;
    assign w_frame_end = w_slot_end && r_idx == LAST_IDX;
    assign w_ext       = {4'h0, r_dp_bcd};
    assign w_nib       = w_ext[{r_idx, 2'b00} +: 4];
    assign w_on        = r_cnt >= BLANK_CNT;

    // w_lz[k] marks digit k as a leading zero; units and sign positions never are
    always_comb begin
        w_lz    = '0;
        w_lz[4] = r_dp_bcd[19:16] == 4'h0;
        for (int k = 3; k >= 1; k--) w_lz[k] = w_lz[k+1] && r_dp_bcd[4*k +: 4] == 4'h0;
    end

    seg7_decode u_dec (
        .i_nib   (w_nib),
        .i_blank (w_lz[r_idx]),
        .o_seg   (w_dig)
    );

    assign w_an  = w_on ? 6'b000001 << r_idx : 6'h00;
    assign w_pat = !w_on ? SEG_BLANK : r_idx == LAST_IDX ? (r_dp_sign ? SEG_MINUS : SEG_BLANK) : w_dig;

    // scan counters, shadow capture and wrap-time commit so a frame never mixes two values
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_idx     <= '0;
            r_sh_bcd  <= '0;
            r_sh_sign <= 1'b0;
            r_dp_bcd  <= '0;
            r_dp_sign <= 1'b0;
        end else begin
            r_cnt <= w_slot_end ? '0 : r_cnt + 1'b1;
            if (w_slot_end) r_idx <= w_frame_end ? '0 : r_idx + 1'b1;
            if (bus.load) {r_sh_bcd, r_sh_sign} <= {bus.bcd, bus.sign};
            if (w_frame_end) {r_dp_bcd, r_dp_sign} <= bus.load ? {bus.bcd, bus.sign} : {r_sh_bcd, r_sh_sign};
        end
    end

    // output stage: one register delay, polarity applied here only
    always_ff @(posedge clk) begin
        if (rst) begin
            r_an  <= AN_POL;
            r_seg <= SEG_BLANK ^ SEG_POL;
            r_fd  <= 1'b0;
        end else begin
            r_an  <= w_an ^ AN_POL;
            r_seg <= w_pat ^ SEG_POL;
            r_fd  <= w_frame_end;
        end
    end

    assign bus.an         = r_an;
    assign bus.seg        = r_seg;
    assign bus.frame_done = r_fd;
endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: frame-level scoreboard check of the scanner with CLK_DIV=4, BLANK_CYCLES=1, active-low outputs
module tb_seg7_scan;
    import seg7_pkg::*;

    typedef struct {
        logic [5:0] an;
        logic [6:0] seg;
        logic       fd;
        int         tag;
    } exp_t;

    typedef struct {
        logic [19:0]      bcd;
        logic             sign;
        int               at;
        logic [5:0][6:0]  pats;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    seg7_scan_if bus();

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   frame_no = 0;

    seg7_scan #(
        .CLK_DIV        (4),
        .BLANK_CYCLES   (1),
        .SEG_ACTIVE_LOW (1),
        .AN_ACTIVE_LOW  (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (bus.an !== e.an || bus.seg !== e.seg || bus.frame_done !== e.fd) begin
                errors++;
                $display("FAIL chk%0d: an=%b want %b, seg=%h want %h, frame_done=%b want %b",
                         e.tag, bus.an, e.an, bus.seg, e.seg, bus.frame_done, e.fd);
            end
        end
    endtask

    task automatic drive(input logic l, input logic [19:0] b, input logic s);
        bus.load = l;
        bus.bcd  = b;
        bus.sign = s;
    endtask

    task automatic idle();
        drive(1'b0, 20'($urandom), 1'($urandom));
    endtask

    function automatic void push_reset(input int tag);
        exp_t e;
        e.an  = 6'h3F;
        e.seg = 7'h7F;
        e.fd  = 1'b0;
        e.tag = tag;
        sb.push_back(e);
    endfunction

    function automatic void push_frame(input logic [5:0][6:0] p, input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            int s;
            int c;
            s = k / 4;
            c = k % 4;
            e.an  = (c == 0) ? 6'h3F : ~(6'b000001 << s);
            e.seg = (c == 0) ? 7'h7F : ~p[s];
            e.fd  = (s == NUM_DIGITS - 1) && (c == 3);
            e.tag = frame_no * 100 + k;
            sb.push_back(e);
        end
        frame_no++;
    endfunction

    task automatic run_frame(input logic [5:0][6:0] p,
                             input int a1, input logic [19:0] b1, input logic s1,
                             input int a2, input logic [19:0] b2, input logic s2);
        push_frame(p, 24);
        for (int i = 0; i < 24; i++) begin
            tick();
            if (i == a1) drive(1'b1, b1, s1);
            else if (i == a2) drive(1'b1, b2, s2);
            else idle();
        end
    endtask

    initial begin
        vec_t v[9];
        logic [5:0][6:0] zero;
        logic [5:0][6:0] nine;
        logic [5:0][6:0] cur;
        zero = {7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h3F};
        nine = {7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h6F};
        v[0] = '{20'h32768, 1'b1, 10, {7'h40, 7'h4F, 7'h5B, 7'h07, 7'h7D, 7'h7F}};
        v[1] = '{20'h00105, 1'b0,  5, {7'h00, 7'h00, 7'h00, 7'h06, 7'h3F, 7'h6D}};
        v[2] = '{20'h0000A, 1'b0,  0, {7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h79}};
        v[3] = '{20'h10005, 1'b0,  7, {7'h00, 7'h06, 7'h3F, 7'h3F, 7'h3F, 7'h6D}};
        v[4] = '{20'h00000, 1'b1, 12, {7'h40, 7'h00, 7'h00, 7'h00, 7'h00, 7'h3F}};
        v[5] = '{20'h99999, 1'b0, 22, {7'h00, 7'h6F, 7'h6F, 7'h6F, 7'h6F, 7'h6F}};
        v[6] = '{20'hF0000, 1'b1,  3, {7'h40, 7'h79, 7'h3F, 7'h3F, 7'h3F, 7'h3F}};
        v[7] = '{20'h00020, 1'b0, 22, {7'h00, 7'h00, 7'h00, 7'h00, 7'h5B, 7'h3F}};
        v[8] = '{20'h0C0B0, 1'b0, 15, {7'h00, 7'h00, 7'h79, 7'h3F, 7'h79, 7'h3F}};

        drive(1'b0, 20'h0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        push_reset(9000);
        push_reset(9001);
        tick();
        tick();
        rst = 1'b0;

        run_frame(zero, -1, 20'h0, 1'b0, -1, 20'h0, 1'b0);
        run_frame(zero, -1, 20'h0, 1'b0, -1, 20'h0, 1'b0);

        cur = zero;
        for (int i = 0; i < 9; i++) begin
            run_frame(cur, v[i].at, v[i].bcd, v[i].sign, -1, 20'h0, 1'b0);
            cur = v[i].pats;
        end
        run_frame(cur, 3, 20'h00001, 1'b0, 22, 20'h00009, 1'b0);
        run_frame(nine, -1, 20'h0, 1'b0, -1, 20'h0, 1'b0);
        cur = nine;

        push_frame(cur, 14);
        for (int i = 0; i < 14; i++) begin
            tick();
            if (i == 2) drive(1'b1, 20'h00777, 1'b1);
            else if (i == 13) begin
                drive(1'b1, 20'h55555, 1'b1);
                rst = 1'b1;
            end else idle();
        end
        push_reset(9100);
        tick();
        rst = 1'b0;
        idle();
        run_frame(zero, -1, 20'h0, 1'b0, -1, 20'h0, 1'b0);
        run_frame(zero, -1, 20'h0, 1'b0, -1, 20'h0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
